// File: rtl/port_out_fifo.sv
// Output-side FIFO between the processor OUT path and an external valid/ready sink.
// Optional almost_full output is enabled by defining PORT_OUT_FIFO_AF_EN.
module port_out_fifo #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned AF_LEVEL = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    input  logic              ovf_clr
`ifdef PORT_OUT_FIFO_AF_EN
    ,
    output logic              almost_full
`endif
);

    localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (ADDR_W != $clog2(DEPTH)) ||
        (AF_LEVEL > DEPTH)) begin : g_param_check
        $error("port_out_fifo: invalid parameter combination");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              push, pop, drop;

    always_comb begin
        full     = (count_q == FullCount);
        empty    = (count_q == '0);
        count    = count_q;
        overflow = overflow_q;
        m_valid  = !empty;
        m_data   = m_valid ? mem_q[rd_ptr_q] : '0;
    end

`ifdef PORT_OUT_FIFO_AF_EN
    always_comb begin
        almost_full = (count_q >= (ADDR_W + 1)'(AF_LEVEL));
    end
`endif

    // A full FIFO still accepts a word when the head leaves in the same cycle.
    always_comb begin
        pop  = m_valid && m_ready;
        push = !reset && wr_en && (!full || pop);
        drop = !reset && wr_en && full && !pop;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (ADDR_W + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (ADDR_W + 1)'(1);
        end
        // Set has priority over clear so a simultaneous drop is never lost.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_port_out_fifo.sv
// Self-checking bench for port_out_fifo: hand-built vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_port_out_fifo;

    localparam int DEPTH = 8;
    localparam int AF    = 6;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_ready;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        ovf_clr;
`ifdef PORT_OUT_FIFO_AF_EN
    logic        almost_full;
`endif

    port_out_fifo #(
        .DATA_W  (16),
        .DEPTH   (DEPTH),
        .ADDR_W  (3),
        .AF_LEVEL(AF)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .overflow(overflow),
        .ovf_clr (ovf_clr)
`ifdef PORT_OUT_FIFO_AF_EN
        ,
        .almost_full(almost_full)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [15:0] mq[$];
    bit          m_ovf;

    typedef struct {
        logic        wr_en;
        logic [15:0] wr_data;
        logic        m_ready;
        logic [3:0]  cnt;
        logic        valid;
        logic [15:0] data;
        logic        full;
        logic        ovf;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mkv(logic w, logic [15:0] d, logic r, logic [3:0] c, logic v,
                                 logic [15:0] od, logic f, logic o);
        vec_t x;
        x.wr_en = w; x.wr_data = d; x.m_ready = r;
        x.cnt = c; x.valid = v; x.data = od; x.full = f; x.ovf = o;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a plain queue of accepted words plus the sticky drop flag.
    task automatic model_step();
        int sz;
        bit do_pop, is_full, do_push, do_drop;
        sz = mq.size();
        if (reset) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            do_pop  = (sz > 0) && m_ready;
            is_full = (sz == DEPTH);
            do_push = wr_en && (!is_full || do_pop);
            do_drop = wr_en && is_full && !do_pop;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(wr_data);
            if (do_drop) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
        end
    endtask

    task automatic compare_model();
        int sz;
        sz = mq.size();
        chk("model_count", count, sz);
        chk("model_valid", m_valid, sz > 0);
        chk("model_data", m_data, (sz > 0) ? mq[0] : 16'h0000);
        chk("model_full", full, sz == DEPTH);
        chk("model_empty", empty, sz == 0);
        chk("model_overflow", overflow, m_ovf);
`ifdef PORT_OUT_FIFO_AF_EN
        chk("model_almost_full", almost_full, sz >= AF);
`endif
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic set_in(logic w, logic [15:0] d, logic r, logic c);
        wr_en = w; wr_data = d; m_ready = r; ovf_clr = c;
    endtask

    initial begin
        logic [15:0] last;
        logic [15:0] got;
        int k;

        reset = 1'b1;
        set_in(1'b0, 16'h0000, 1'b0, 1'b0);
        m_ovf = 1'b0;

        // Table: stall hold on a single word, then fill / overflow / drain.
        k = 0;
        vecs[k++] = mkv(1'b1, 16'hA5A5, 1'b0, 4'd1, 1'b1, 16'hA5A5, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            vecs[k++] = mkv(1'b0, 16'h0000, 1'b0, 4'd1, 1'b1, 16'hA5A5, 1'b0, 1'b0);
        vecs[k++] = mkv(1'b0, 16'h0000, 1'b1, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            vecs[k++] = mkv(1'b1, 16'(i + 1), 1'b0, 4'(i + 1), 1'b1, 16'h0001, i == 7, 1'b0);
        vecs[k++] = mkv(1'b1, 16'h0009, 1'b0, 4'd8, 1'b1, 16'h0001, 1'b1, 1'b1);
        for (int j = 0; j < 8; j++)
            vecs[k++] = mkv(1'b0, 16'h0000, 1'b1, 4'(7 - j), j < 7,
                            (j < 7) ? 16'(j + 2) : 16'h0000, 1'b0, 1'b1);

        // Reset state.
        cycle();
        cycle();
        chk("reset_count", count, 0);
        chk("reset_empty", empty, 1);
        chk("reset_full", full, 0);
        chk("reset_valid", m_valid, 0);
        chk("reset_data", m_data, 0);
        chk("reset_overflow", overflow, 0);
        reset = 1'b0;

        for (int i = 0; i < 24; i++) begin
            set_in(vecs[i].wr_en, vecs[i].wr_data, vecs[i].m_ready, 1'b0);
            cycle();
            chk($sformatf("vec%0d_count", i), count, vecs[i].cnt);
            chk($sformatf("vec%0d_valid", i), m_valid, vecs[i].valid);
            chk($sformatf("vec%0d_data", i), m_data, vecs[i].data);
            chk($sformatf("vec%0d_full", i), full, vecs[i].full);
            chk($sformatf("vec%0d_ovf", i), overflow, vecs[i].ovf);
        end

        // Full with simultaneous push and pop.
        set_in(1'b0, 16'h0000, 1'b0, 1'b1);
        cycle();
        chk("clr_overflow", overflow, 0);
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 16'(16'h0010 + i), 1'b0, 1'b0);
            cycle();
        end
        chk("fill_full", full, 1);
        set_in(1'b1, 16'h00FF, 1'b1, 1'b0);
        cycle();
        chk("pushpop_count", count, 8);
        chk("pushpop_overflow", overflow, 0);
        chk("pushpop_head", m_data, 16'h0011);
        last = 16'h0000;
        set_in(1'b0, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (m_valid) last = m_data;
            cycle();
        end
        chk("pushpop_last", last, 16'h00FF);
        chk("pushpop_empty", empty, 1);

        // Write/pop pairs across the pointer wrap.
        set_in(1'b1, 16'h0100, 1'b0, 1'b0);
        cycle();
        for (int i = 1; i <= 10; i++) begin
            got = m_data;
            chk($sformatf("wrap_order%0d", i), got, 16'(16'h0100 + i - 1));
            set_in(1'b1, 16'(16'h0100 + i), 1'b1, 1'b0);
            cycle();
            chk($sformatf("wrap_count%0d", i), count <= 4'd2, 1);
        end
        chk("wrap_order_last", m_data, 16'h010A);
        set_in(1'b0, 16'h0000, 1'b1, 1'b0);
        cycle();
        chk("wrap_empty", empty, 1);

        // Reset mid-stream with a write in the reset cycle.
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0);
            cycle();
        end
        chk("load5_count", count, 5);
        reset = 1'b1;
        set_in(1'b1, 16'hBEEF, 1'b0, 1'b0);
        cycle();
        chk("midrst_count", count, 0);
        chk("midrst_valid", m_valid, 0);
        chk("midrst_data", m_data, 0);
        chk("midrst_overflow", overflow, 0);
        reset = 1'b0;
        set_in(1'b0, 16'h0000, 1'b0, 1'b0);
        cycle();
        chk("midrst_write_lost", count, 0);

`ifdef PORT_OUT_FIFO_AF_EN
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 16'(16'h0300 + i), 1'b0, 1'b0);
            cycle();
            chk($sformatf("af_rise%0d", i + 1), almost_full, (i + 1) >= AF);
        end
        set_in(1'b1, 16'h0399, 1'b0, 1'b1);
        cycle();
        chk("af_set_wins", overflow, 1);
        set_in(1'b0, 16'h0000, 1'b1, 1'b0);
        for (int j = 0; j < 8; j++) begin
            cycle();
            chk($sformatf("af_fall%0d", 7 - j), almost_full, (7 - j) >= AF);
        end
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            reset   = ($urandom_range(99) == 0);
            wr_en   = $urandom_range(1);
            wr_data = 16'($urandom);
            m_ready = ($urandom_range(9) < 4);
            ovf_clr = ($urandom_range(19) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
